// File: rtl/intr_ctrl_if.sv
// IO register bus for intr_ctrl: single-cycle strobe, ack and read data one cycle later.
interface intr_ctrl_if;
   logic        stb;
   logic        we;
   logic [1:0]  adr;
   logic [31:0] din;
   logic [31:0] dout;
   logic        ack;

   modport master (output stb, we, adr, din, input dout, ack);
   modport slave  (input stb, we, adr, din, output dout, ack);
endinterface

// File: rtl/intr_ctrl.sv
// Priority interrupt controller: synchronised edge capture, EN/PEND/CUR/CTRL registers, IDLE/REQ/SERVICE FSM.
// Optional CPU abort strobe enabled by defining INTR_CTRL_ABORT_EN.
module intr_ctrl #(
   parameter int unsigned NUM_INT = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_INT-1:0] int_in,
   input  logic               intack,
   input  logic               rti,
   output logic               irq,
   output logic               intabort,
   intr_ctrl_if.slave         bus
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t             state;
   logic [NUM_INT-1:0] sync1, sync2, sync3;
   logic [2:0]         armed;
   logic [NUM_INT-1:0] edges, en, pend, qual_vec, sel_1h, pend_clr, w1c;
   logic [3:0]         cur_idx, sel_idx;
   logic               insvc, qual, take, found;
   logic               wr_en, wr_pend;
   logic [31:0]        rdata;
   logic               unused_din;

   assign unused_din = ^bus.din[31:NUM_INT];

   // armed fills one stage per clock after reset, so inputs already high at
   // release never register as edges until they fall and rise again.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= '0;
         sync2 <= '0;
         sync3 <= '0;
         armed <= '0;
      end else begin
         sync1 <= int_in;
         sync2 <= sync1;
         sync3 <= sync2;
         armed <= {armed[1:0], 1'b1};
      end
   end

   assign edges    = sync2 & ~sync3 & {NUM_INT{armed[2]}};
   assign qual_vec = pend & en;
   assign qual     = |qual_vec;
   assign take     = (state == REQ) && intack && qual;
   assign wr_en    = bus.stb && bus.we && (bus.adr == 2'd0);
   assign wr_pend  = bus.stb && bus.we && (bus.adr == 2'd1);
   assign w1c      = wr_pend ? bus.din[NUM_INT-1:0] : '0;
   assign pend_clr = w1c | (take ? sel_1h : '0);

   always_comb begin
      sel_1h  = '0;
      sel_idx = '0;
      found   = 1'b0;
      for (int unsigned i = 0; i < NUM_INT; i++) begin
         if (qual_vec[i] && !found) begin
            found     = 1'b1;
            sel_1h[i] = 1'b1;
            sel_idx   = 4'(i);
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (bus.adr)
         2'd0:    rdata = 32'(en);
         2'd1:    rdata = 32'(pend);
         2'd2:    rdata = {insvc, 27'b0, cur_idx};
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en       <= '0;
         pend     <= '0;
         bus.ack  <= 1'b0;
         bus.dout <= '0;
      end else begin
         if (wr_en) en <= bus.din[NUM_INT-1:0];
         pend     <= (pend & ~pend_clr) | edges;
         bus.ack  <= bus.stb;
         bus.dout <= bus.stb ? rdata : '0;
      end
   end

`ifdef INTR_CTRL_ABORT_EN
   logic wr_ctrl;
   assign wr_ctrl = bus.stb && bus.we && (bus.adr == 2'd3);
`else
   assign intabort = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         irq      <= 1'b0;
         cur_idx  <= '0;
         insvc    <= 1'b0;
`ifdef INTR_CTRL_ABORT_EN
         intabort <= 1'b0;
`endif
      end else begin
`ifdef INTR_CTRL_ABORT_EN
         intabort <= 1'b0;
`endif
         case (state)
            IDLE: begin
               irq <= 1'b0;
               if (qual) begin
                  state <= REQ;
                  irq   <= 1'b1;
               end
            end
            REQ: begin
               if (take) begin
                  cur_idx <= sel_idx;
                  insvc   <= 1'b1;
                  irq     <= 1'b0;
                  state   <= SERVICE;
               end else if (!qual) begin
                  irq   <= 1'b0;
                  state <= IDLE;
               end
            end
            SERVICE: begin
               irq <= 1'b0;
               if (rti) begin
                  insvc <= 1'b0;
                  state <= IDLE;
               end
`ifdef INTR_CTRL_ABORT_EN
               else if (wr_ctrl && bus.din[0]) begin
                  intabort <= 1'b1;
                  insvc    <= 1'b0;
                  state    <= IDLE;
               end
`endif
            end
            default: begin
               irq   <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed vector bench for intr_ctrl: table of per-cycle stimulus/expectations plus reset and clear-race sequences.
module tb_intr_ctrl;

   typedef struct {
      logic        stb;
      logic        we;
      logic [1:0]  adr;
      logic [31:0] din;
      logic [7:0]  intv;
      logic        ia;
      logic        rt;
      logic        exp_irq;
      logic        exp_abort;
      logic [31:0] exp_dout;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] int_in;
   logic       intack, rti, irq, intabort;
   logic [7:0] hold = '0;
   int         total = 0;
   int         bad = 0;
   vec_t       tbl[$];

   intr_ctrl_if bus_if ();

   intr_ctrl #(.NUM_INT(8)) dut (
      .clk(clk), .rst(rst), .int_in(int_in), .intack(intack), .rti(rti),
      .irq(irq), .intabort(intabort), .bus(bus_if)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic stb, logic we, logic [1:0] adr, logic [31:0] din,
                               logic [7:0] intv, logic ia, logic rt, logic eirq, logic [31:0] edout);
      vec_t v;
      v.stb = stb; v.we = we; v.adr = adr; v.din = din; v.intv = intv;
      v.ia = ia; v.rt = rt; v.exp_irq = eirq; v.exp_abort = 1'b0; v.exp_dout = edout;
      return v;
   endfunction

   function automatic vec_t wr(logic [1:0] a, logic [31:0] d, logic e);
      return mk(1, 1, a, d, 8'h00, 0, 0, e, 32'h0);
   endfunction
   function automatic vec_t rd(logic [1:0] a, logic [31:0] d, logic e);
      return mk(1, 0, a, 32'h0, 8'h00, 0, 0, e, d);
   endfunction
   function automatic vec_t pl(logic [7:0] m, logic e);
      return mk(0, 0, 2'd0, 32'h0, m, 0, 0, e, 32'h0);
   endfunction
   function automatic vec_t id(logic e);
      return mk(0, 0, 2'd0, 32'h0, 8'h00, 0, 0, e, 32'h0);
   endfunction
   function automatic vec_t ak(logic e);
      return mk(0, 0, 2'd0, 32'h0, 8'h00, 1, 0, e, 32'h0);
   endfunction
   function automatic vec_t rt(logic e);
      return mk(0, 0, 2'd0, 32'h0, 8'h00, 0, 1, e, 32'h0);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      @(negedge clk);
      bus_if.stb = v.stb; bus_if.we = v.we; bus_if.adr = v.adr; bus_if.din = v.din;
      int_in = v.intv | hold; intack = v.ia; rti = v.rt;
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v, input string nm);
      drive(v);
      chk({nm, " irq"}, 32'(irq), 32'(v.exp_irq));
      chk({nm, " ack"}, 32'(bus_if.ack), 32'(v.stb));
      chk({nm, " abort"}, 32'(intabort), 32'(v.exp_abort));
      if (v.stb && !v.we) chk({nm, " dout"}, bus_if.dout, v.exp_dout);
   endtask

   task automatic reset_outputs_zero(input string nm);
      chk({nm, " irq"}, 32'(irq), 32'h0);
      chk({nm, " abort"}, 32'(intabort), 32'h0);
      chk({nm, " ack"}, 32'(bus_if.ack), 32'h0);
      chk({nm, " dout"}, bus_if.dout, 32'h0);
   endtask

   initial begin
      vec_t v;
      bit   seen;

      // reset state and register map
      tbl.push_back(rd(0, 32'h0, 0)); tbl.push_back(rd(1, 32'h0, 0));
      tbl.push_back(rd(2, 32'h0, 0)); tbl.push_back(rd(3, 32'h0, 0));
      // priority order and irq low gap between services
      tbl.push_back(wr(0, 32'h05, 0)); tbl.push_back(pl(8'h04, 0)); tbl.push_back(pl(8'h01, 0));
      tbl.push_back(id(0)); tbl.push_back(id(1)); tbl.push_back(rd(1, 32'h05, 1));
      tbl.push_back(ak(0)); tbl.push_back(rd(2, 32'h80000000, 0)); tbl.push_back(rd(1, 32'h04, 0));
      tbl.push_back(rt(0)); tbl.push_back(id(1)); tbl.push_back(ak(0));
      tbl.push_back(rd(2, 32'h80000002, 0)); tbl.push_back(rt(0));
      tbl.push_back(rd(2, 32'h00000002, 0)); tbl.push_back(rd(1, 32'h0, 0));
      // masked source pends, enabling raises irq
      tbl.push_back(wr(0, 32'h00, 0)); tbl.push_back(pl(8'h08, 0)); tbl.push_back(id(0));
      tbl.push_back(id(0)); tbl.push_back(rd(1, 32'h08, 0)); tbl.push_back(id(0));
      tbl.push_back(wr(0, 32'h08, 0)); tbl.push_back(id(1));
      // W1C in REQ withdraws the request; intack in IDLE ignored
      tbl.push_back(wr(1, 32'hFF, 1)); tbl.push_back(id(0)); tbl.push_back(rd(1, 32'h0, 0));
      tbl.push_back(ak(0)); tbl.push_back(rd(2, 32'h00000002, 0));
      // edge during SERVICE pends without irq; rti in REQ ignored
      tbl.push_back(wr(0, 32'h0A, 0)); tbl.push_back(pl(8'h08, 0)); tbl.push_back(id(0));
      tbl.push_back(id(0)); tbl.push_back(id(1)); tbl.push_back(ak(0));
      tbl.push_back(pl(8'h02, 0)); tbl.push_back(id(0)); tbl.push_back(id(0)); tbl.push_back(id(0));
      tbl.push_back(rd(1, 32'h02, 0)); tbl.push_back(rd(2, 32'h80000003, 0));
      tbl.push_back(rt(0)); tbl.push_back(id(1)); tbl.push_back(rt(1)); tbl.push_back(ak(0));
      tbl.push_back(rd(2, 32'h80000001, 0));
      // CTRL abort in SERVICE
      v = wr(3, 32'h1, 0);
`ifdef INTR_CTRL_ABORT_EN
      v.exp_abort = 1'b1;
      tbl.push_back(v); tbl.push_back(rd(2, 32'h00000001, 0));
`else
      tbl.push_back(v); tbl.push_back(rd(2, 32'h80000001, 0));
`endif
      tbl.push_back(rt(0)); tbl.push_back(rd(2, 32'h00000001, 0));
      tbl.push_back(wr(2, 32'hFFFFFFFF, 0)); tbl.push_back(rd(2, 32'h00000001, 0));
      tbl.push_back(rd(3, 32'h0, 0)); tbl.push_back(rd(0, 32'h0A, 0));

      rst = 1'b0; int_in = '0; intack = 0; rti = 0;
      bus_if.stb = 0; bus_if.we = 0; bus_if.adr = '0; bus_if.din = '0;
      repeat (3) @(posedge clk);
      #1;
      reset_outputs_zero("por");
      @(negedge clk) rst = 1'b1;
      repeat (4) drive(id(0));

      foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

      // reset during SERVICE with source 4 held high
      apply(wr(0, 32'h10, 0), "r32 en");
      hold = 8'h10;
      apply(id(0), "r32 a"); apply(id(0), "r32 b"); apply(id(0), "r32 c"); apply(id(1), "r32 d");
      apply(ak(0), "r32 ack"); apply(rd(2, 32'h80000004, 0), "r32 cur");
      @(negedge clk);
      rst = 1'b0; bus_if.stb = 0; bus_if.we = 0; intack = 0; rti = 0;
      #1;
      reset_outputs_zero("r32 async");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      apply(rd(0, 32'h0, 0), "r32 en0"); apply(rd(1, 32'h0, 0), "r32 pend0");
      apply(rd(2, 32'h0, 0), "r32 cur0"); apply(wr(0, 32'h10, 0), "r32 en1");
      for (int i = 0; i < 8; i++) apply(id(0), $sformatf("r32 held%0d", i));
      apply(rd(1, 32'h0, 0), "r32 pend1");
      hold = 8'h00;
      repeat (4) apply(id(0), "r32 low");
      hold = 8'h10;
      seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
         drive(id(0));
         if (irq) seen = 1;
      end
      chk("r32 irq after toggle", 32'(seen), 32'h1);
      if (seen) begin
         apply(ak(0), "r32 ack2"); apply(rd(2, 32'h80000004, 0), "r32 cur2");
         apply(rt(0), "r32 rti");
      end
      hold = 8'h00;

      // edge arriving in the same cycle as its W1C keeps PEND set
      apply(wr(0, 32'h00, 0), "race en");
      apply(pl(8'h20, 0), "race p0"); apply(id(0), "race i0"); apply(id(0), "race i1");
      apply(rd(1, 32'h20, 0), "race pend0");
      apply(pl(8'h20, 0), "race p1"); apply(id(0), "race i2");
      apply(wr(1, 32'h20, 0), "race w1c");
      apply(rd(1, 32'h20, 0), "race pend1");
      apply(wr(1, 32'h20, 0), "race w1c2");
      apply(rd(1, 32'h0, 0), "race pend2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have parameter NUM_INT, default 8, number of interrupt sources (2..16).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port int_in  input  NUM_INT  level/pulse interrupt requests; bit 0 highest priority.
REQ-005 SHALL have port intack  input  1  CPU interrupt-acknowledge strobe, one cycle.
REQ-006 SHALL have port rti  input  1  CPU return-from-interrupt strobe, one cycle.
REQ-007 SHALL have port irq  output  1  interrupt request to CPU edge detector.
REQ-008 SHALL have port intabort  output  1  abort strobe to CPU; see Configuration.
REQ-009 SHALL have ports stb input 1, we input 1, adr input 2, din input 32, dout output 32, ack output 1  IO register access.

Function
REQ-010 SHALL sample int_in through a two-flop synchroniser, then rising-edge detect; each detected edge sets the corresponding pending bit.
REQ-011 SHALL hold registers: EN (adr 0, RW, NUM_INT bits), PEND (adr 1, R; write-1-to-clear), CUR (adr 2, R, index of source in service, bit 31 = in-service flag), CTRL (adr 3, W).
REQ-012 SHALL qualify request as |(PEND & EN).
REQ-013 SHALL implement FSM IDLE, REQ, SERVICE.
REQ-014 IDLE: irq=0; on qualified request go REQ next cycle.
REQ-015 REQ: irq=1; on intack latch lowest-index set bit of PEND&EN into CUR, clear that PEND bit, set in-service flag, go SERVICE; irq drops the cycle after intack.
REQ-016 REQ: if qualified request vanishes (EN or PEND cleared by software) before intack, return to IDLE with irq=0.
REQ-017 SERVICE: irq=0; new edges still set PEND; on rti clear in-service flag, go IDLE.
REQ-018 After SERVICE->IDLE with a qualified request still present, irq SHALL be low for at least one full cycle before reasserting, guaranteeing a CPU-visible rising edge.
REQ-019 Edge on a source in the same cycle its PEND bit is cleared (by intack or W1C) SHALL leave the bit set.
REQ-020 intack arriving in IDLE or SERVICE SHALL be ignored; rti in IDLE or REQ SHALL be ignored.
REQ-021 IO: ack SHALL assert exactly one cycle after stb; dout valid with ack; unused bits read 0; write to read-only registers ignored.
REQ-022 Priority selection SHALL be combinational over NUM_INT bits, result registered at intack.

Reset
REQ-023 On rst low: FSM=IDLE, irq=0, intabort=0, EN=0, PEND=0, CUR=0, ack=0, dout=0, synchroniser flops=0.
REQ-024 Reset mid-REQ or mid-SERVICE SHALL discard all pending and in-service state; no edge SHALL be detected from inputs already high when reset releases until they go low and high again.

Configuration
REQ-025 Macro INTR_CTRL_ABORT_EN SHALL gate the abort feature.
REQ-026 With INTR_CTRL_ABORT_EN defined: write to CTRL with din[0]=1 while in SERVICE SHALL pulse intabort for exactly one cycle, clear in-service flag and go IDLE; write in other states ignored.
REQ-027 Without INTR_CTRL_ABORT_EN: intabort SHALL be constant 0, CTRL writes ignored, no related logic.

Verification
REQ-028 EN=0x05, pulse int_in[2] then int_in[0] one cycle apart -> irq rises; on intack CUR=0x80000000; after rti irq low >=1 cycle, rises again; next intack CUR=0x80000002.
REQ-029 EN=0x00, pulse int_in[3] -> PEND=0x08, irq stays 0; write EN=0x08 -> irq=1 within 2 cycles.
REQ-030 In REQ, W1C PEND with 0xFF before intack -> FSM IDLE, irq=0, PEND=0.
REQ-031 In SERVICE, pulse int_in[1] (EN bit set) -> irq stays 0, PEND bit 1 set; after rti irq rises.
REQ-032 Assert rst low during SERVICE with int_in[4] held high -> all registers 0; after release no irq until int_in[4] toggles.
REQ-033 With INTR_CTRL_ABORT_EN, write CTRL=1 in SERVICE -> intabort high one cycle, CUR bit 31=0, FSM IDLE; without macro intabort never asserts.
